button_event_classifier: RTL and testbench
==========================================

// Module: button_event_classifier
//
// PURPOSE
//   Consumes the debounced level from the debouncer stage and classifies each
//   press as a short press, a long press or a double click.
//   For every gesture it emits a single-cycle event pulse.
//   Sits between the debouncer and the user-interface control logic.
//   A level that is already stable and glitch-free is required at the input.
//
// PARAMETERS
//   ClkFreq        100_000_000  clock frequency in Hz; must be a multiple of 1000
//   LongPressMs    800          hold time in ms that qualifies a long press
//   DoubleClickMs  250          max release-to-press gap in ms for a double click
//
// PORTS
//   clk_i     in   1  system clock, rising-edge active
//   rst_i     in   1  reset, asynchronous, active-high
//   level_i   in   1  debounced button level (1 = pressed)
//   short_o   out  1  1-cycle pulse: short press completed
//   long_o    out  1  1-cycle pulse: long-press threshold reached
//   double_o  out  1  1-cycle pulse: second press of a double click
//   held_o    out  1  high while a long press is still held
//
// BEHAVIOUR
//   Derived constants:
//   - LongCycles = ClkFreq/1000*LongPressMs
//   - DblCycles  = ClkFreq/1000*DoubleClickMs
//   - Both must be >= 2, else elaboration error.
//   - Counter width is $clog2(max(LongCycles,DblCycles)+1); no wrap is ever
//     reached in a legal state.
//
//   Edge detect:
//   - prev_q registers level_i.
//   - rise = level_i & ~prev_q; fall = ~level_i & prev_q.
//
//   Reset (async, any time, including mid-gesture):
//   - state=IDLE, cnt=0, prev_q=1.
//   - short_o, long_o, double_o and held_o are all 0.
//   - No pulse is emitted for an interrupted gesture.
//   - prev_q=1 means a button held through reset must be released and pressed
//     again before anything is detected.
//
//   States:
//   - IDLE:  on rise -> PRESS, cnt<=0.
//   - PRESS: cnt++ each cycle.
//     - fall -> WAIT, cnt<=0.
//     - else if cnt==LongCycles-1 -> LONG, long_o<=1.
//     - Fall takes priority over the threshold in the same cycle.
//   - LONG:  held_o=1 (registered; 1 from the cycle long_o is high); on fall
//     -> IDLE. No short_o follows a long press.
//   - WAIT:  cnt++ each cycle.
//     - rise -> DPRESS, double_o<=1.
//     - else if cnt==DblCycles-1 -> IDLE, short_o<=1.
//     - Rise takes priority over timeout in the same cycle.
//   - DPRESS: waits for fall -> IDLE. No long detection and no further pulses.
//
//   Latency (rise sampled at edge R, fall sampled at edge F):
//   - long_o is high in the cycle following edge R+LongCycles.
//   - short_o is high in the cycle following edge F+DblCycles.
//   - double_o is high in the cycle following the second rise edge.
//
//   Output rules:
//   - All outputs are registered.
//   - Pulses are exactly 1 cycle wide.
//   - At most one of short_o, long_o, double_o is high in any cycle.
//   - A triple click reports double_o followed by one short_o for the third
//     press.
//
// TESTING  (ClkFreq=10_000, LongPressMs=5, DoubleClickMs=3 -> LongCycles=50, DblCycles=30)
//   1. Press 10 cycles, release, idle 40 -> one short_o exactly 30 cycles
//      after the fall edge; no long_o, no double_o.
//   2. Press 60 cycles -> long_o 50 cycles after rise; held_o high until the
//      cycle after release; no short_o afterwards.
//   3. Press 5, release 10, press 5, release -> one double_o in the cycle
//      after the second rise; no short_o for either press.
//   4. Release exactly at cycle 50 of a press -> WAIT path: short_o after
//      timeout, no long_o. Second press exactly at cycle 30 of WAIT ->
//      double_o, no short_o.
//   5. Assert rst_i mid-PRESS and mid-WAIT (button held / released) -> all
//      outputs 0 immediately, no pulse. Button held through reset gives no
//      event until it is released and pressed again.
//   6. Random press/release stream against a reference model -> pulse
//      counts match and no two pulses overlap.

Source files
------------

// File: rtl/button_event_classifier_if.sv
// Signal bundle between the button source and the event classifier.
// The source (master) drives the debounced level; the classifier (slave) returns event pulses.
interface button_event_classifier_if;
  logic level_i;
  logic short_o;
  logic long_o;
  logic double_o;
  logic held_o;

  modport master (
    output level_i,
    input  short_o,
    input  long_o,
    input  double_o,
    input  held_o
  );

  modport slave (
    input  level_i,
    output short_o,
    output long_o,
    output double_o,
    output held_o
  );
endinterface

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short press, long press and double click,
// emitting one registered single-cycle pulse per gesture.
module button_event_classifier #(
  parameter int ClkFreq       = 100_000_000,
  parameter int LongPressMs   = 800,
  parameter int DoubleClickMs = 250
) (
  input logic                      clk_i,
  input logic                      rst_i,
  button_event_classifier_if.slave bus
);

  localparam int LongCycles = ClkFreq / 1000 * LongPressMs;
  localparam int DblCycles  = ClkFreq / 1000 * DoubleClickMs;
  localparam int MaxCycles  = (LongCycles > DblCycles) ? LongCycles : DblCycles;
  localparam int CntW       = $clog2(MaxCycles + 1);

  if (ClkFreq % 1000 != 0) begin : g_bad_clk_freq
    $error("button_event_classifier: ClkFreq must be a multiple of 1000");
  end
  if (LongCycles < 2 || DblCycles < 2) begin : g_bad_cycles
    $error("button_event_classifier: LongCycles and DblCycles must both be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    LONG,
    WAIT,
    DPRESS
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic            prev_q;
  logic            short_q;
  logic            long_q;
  logic            double_q;
  logic            held_q;
  logic            rise;
  logic            fall;

  assign rise = bus.level_i & ~prev_q;
  assign fall = ~bus.level_i & prev_q;

  // prev_q resets high so a button held through reset must be released before it counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_q   <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      prev_q   <= bus.level_i;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS;
            cnt   <= '0;
          end
        end
        PRESS: begin
          cnt <= cnt + CntW'(1);
          if (fall) begin
            state <= WAIT;
            cnt   <= '0;
          end else if (cnt == CntW'(LongCycles - 1)) begin
            state  <= LONG;
            long_q <= 1'b1;
            held_q <= 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state  <= IDLE;
            held_q <= 1'b0;
          end
        end
        // A second press inside the window wins over a timeout on the same edge.
        WAIT: begin
          cnt <= cnt + CntW'(1);
          if (rise) begin
            state    <= DPRESS;
            double_q <= 1'b1;
          end else if (cnt == CntW'(DblCycles - 1)) begin
            state   <= IDLE;
            short_q <= 1'b1;
          end
        end
        DPRESS: begin
          if (fall) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.short_o  = short_q;
  assign bus.long_o   = long_q;
  assign bus.double_o = double_q;
  assign bus.held_o   = held_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed and stream tests for button_event_classifier with LongCycles=50, DblCycles=30.
// Pulses are recorded by a negedge monitor; expectations are computed from stimulus timing.
module tb_button_event_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  button_event_classifier_if bus ();

  button_event_classifier #(
    .ClkFreq      (10_000),
    .LongPressMs  (5),
    .DoubleClickMs(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int n_short = 0;
  int n_long = 0;
  int n_double = 0;
  int n_overlap = 0;
  int last_short_cyc = -1;
  int last_long_cyc = -1;
  int last_double_cyc = -1;

  // cyc at a negedge equals the index of the posedge that produced the outputs seen there.
  always @(negedge clk) begin
    if (bus.short_o === 1'b1) begin
      n_short++;
      last_short_cyc = cyc;
    end
    if (bus.long_o === 1'b1) begin
      n_long++;
      last_long_cyc = cyc;
    end
    if (bus.double_o === 1'b1) begin
      n_double++;
      last_double_cyc = cyc;
    end
    if ((int'(bus.short_o === 1'b1) + int'(bus.long_o === 1'b1) + int'(bus.double_o === 1'b1)) > 1)
      n_overlap++;
  end

  int n_checks = 0;
  int n_fail = 0;
  int base_short, base_long, base_double, base_overlap;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lvl, input int n);
    bus.level_i = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic startWindow();
    base_short   = n_short;
    base_long    = n_long;
    base_double  = n_double;
    base_overlap = n_overlap;
  endtask

  int r, f, r2;
  int p, gap;
  int e_short, e_long, e_double;
  bit second;

  initial begin
    bus.level_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_short", int'(bus.short_o), 0);
    checkOutput("rst_long", int'(bus.long_o), 0);
    checkOutput("rst_double", int'(bus.double_o), 0);
    checkOutput("rst_held", int'(bus.held_o), 0);
    rst = 1'b0;
    applyStimulus(1'b0, 5);

    $display("[TB] short press");
    startWindow();
    applyStimulus(1'b1, 10);
    f = cyc + 1;
    applyStimulus(1'b0, 40);
    checkOutput("t1_short_count", n_short - base_short, 1);
    checkOutput("t1_short_cycle", last_short_cyc, f + 30);
    checkOutput("t1_long_count", n_long - base_long, 0);
    checkOutput("t1_double_count", n_double - base_double, 0);

    $display("[TB] long press");
    startWindow();
    r = cyc + 1;
    applyStimulus(1'b1, 60);
    checkOutput("t2_long_count", n_long - base_long, 1);
    checkOutput("t2_long_cycle", last_long_cyc, r + 50);
    checkOutput("t2_held_while_pressed", int'(bus.held_o), 1);
    applyStimulus(1'b0, 1);
    checkOutput("t2_held_after_release", int'(bus.held_o), 0);
    applyStimulus(1'b0, 40);
    checkOutput("t2_short_count", n_short - base_short, 0);
    checkOutput("t2_double_count", n_double - base_double, 0);

    $display("[TB] double click");
    startWindow();
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 10);
    r2 = cyc + 1;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 40);
    checkOutput("t3_double_count", n_double - base_double, 1);
    checkOutput("t3_double_cycle", last_double_cyc, r2);
    checkOutput("t3_short_count", n_short - base_short, 0);
    checkOutput("t3_long_count", n_long - base_long, 0);

    $display("[TB] release on the long threshold edge");
    startWindow();
    applyStimulus(1'b1, 50);
    f = cyc + 1;
    applyStimulus(1'b0, 40);
    checkOutput("t4a_long_count", n_long - base_long, 0);
    checkOutput("t4a_short_count", n_short - base_short, 1);
    checkOutput("t4a_short_cycle", last_short_cyc, f + 30);

    $display("[TB] second press on the timeout edge");
    startWindow();
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 30);
    r2 = cyc + 1;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 40);
    checkOutput("t4b_double_count", n_double - base_double, 1);
    checkOutput("t4b_double_cycle", last_double_cyc, r2);
    checkOutput("t4b_short_count", n_short - base_short, 0);

    $display("[TB] press one cycle past the long threshold");
    startWindow();
    r = cyc + 1;
    applyStimulus(1'b1, 51);
    applyStimulus(1'b0, 40);
    checkOutput("t4c_long_count", n_long - base_long, 1);
    checkOutput("t4c_long_cycle", last_long_cyc, r + 50);
    checkOutput("t4c_short_count", n_short - base_short, 0);

    $display("[TB] gap one cycle past the double window");
    startWindow();
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 31);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 40);
    checkOutput("t4d_short_count", n_short - base_short, 2);
    checkOutput("t4d_double_count", n_double - base_double, 0);

    $display("[TB] reset during long hold");
    applyStimulus(1'b1, 55);
    checkOutput("t5_held_before_rst", int'(bus.held_o), 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_held_in_rst", int'(bus.held_o), 0);
    checkOutput("t5_long_in_rst", int'(bus.long_o), 0);
    applyStimulus(1'b1, 3);
    rst = 1'b0;
    startWindow();
    applyStimulus(1'b1, 60);
    checkOutput("t5_long_after_rst", n_long - base_long, 0);
    checkOutput("t5_held_after_rst", int'(bus.held_o), 0);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 10);
    f = cyc + 1;
    applyStimulus(1'b0, 40);
    checkOutput("t5_short_after_repress", n_short - base_short, 1);
    checkOutput("t5_short_cycle", last_short_cyc, f + 30);

    $display("[TB] reset during release window");
    startWindow();
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 10);
    rst = 1'b1;
    #1;
    checkOutput("t5_short_in_rst", int'(bus.short_o), 0);
    applyStimulus(1'b0, 3);
    rst = 1'b0;
    applyStimulus(1'b0, 40);
    checkOutput("t5_wait_short_count", n_short - base_short, 0);
    checkOutput("t5_wait_double_count", n_double - base_double, 0);

    $display("[TB] random gesture stream");
    startWindow();
    e_short = 0;
    e_long = 0;
    e_double = 0;
    second = 1'b0;
    for (int g = 0; g < 40; g++) begin
      p = int'($urandom_range(70, 1));
      gap = int'($urandom_range(45, 1));
      if (g == 39) gap = 45;
      applyStimulus(1'b1, p);
      applyStimulus(1'b0, gap);
      if (second) second = 1'b0;
      else if (p > 50) e_long++;
      else if (gap <= 30) begin
        e_double++;
        second = 1'b1;
      end else e_short++;
    end
    applyStimulus(1'b0, 40);
    checkOutput("t6_short_count", n_short - base_short, e_short);
    checkOutput("t6_long_count", n_long - base_long, e_long);
    checkOutput("t6_double_count", n_double - base_double, e_double);
    checkOutput("t6_overlap_count", n_overlap - base_overlap, 0);
    checkOutput("all_overlap_count", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
